// File: rtl/tron_mechanics_if.sv
// Plot stream between the game logic and the VGA display driver.
//   plot_x/plot_y/plot_colour : pixel to draw, held stable while plot_valid is high
//   plot_valid                : request valid (driven by the game logic)
//   plot_ready                : display accepts; a plot transfers on valid & ready at a rising edge
interface tron_mechanics_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic [X_W-1:0] plot_x;
  logic [Y_W-1:0] plot_y;
  logic [2:0]     plot_colour;
  logic           plot_valid;
  logic           plot_ready;

  modport master (output plot_x, plot_y, plot_colour, plot_valid, input plot_ready);
  modport slave  (input plot_x, plot_y, plot_colour, plot_valid, output plot_ready);
endinterface

// File: rtl/tron_mechanics.sv
// Two-player light-cycle game logic.
// Keeps both heads, their headings and a 1-bit trail occupancy RAM; on each move
// tick it advances both heads, detects crashes and streams plots to the display.
//   CLOCK_50, reset : clock, asynchronous active-high reset
//   KEY_PRESSED     : [2:0] P1 steering code, [5:3] P2 steering code (1xx = direction)
//   clonke          : one-cycle move tick (honoured only while waiting in RUN)
//   start           : one-cycle pulse; leaves IDLE or restarts from GAME_OVER
//   plot            : plot request stream (master side)
//   game_over       : high in GAME_OVER
//   winner          : {P1 crashed, P2 crashed} latched at game end, else 00
module tron_mechanics #(
  parameter int       GRID_W    = 160,
  parameter int       GRID_H    = 120,
  parameter int       X_W       = 8,
  parameter int       Y_W       = 7,
  parameter int       P1_X0     = 40,
  parameter int       P2_X0     = 119,
  parameter int       Y0        = 60,
  parameter bit [2:0] P1_COLOUR = 3'b100,
  parameter bit [2:0] P2_COLOUR = 3'b001
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [5:0]              KEY_PRESSED,
  input  logic                    clonke,
  input  logic                    start,
  tron_mechanics_if.master        plot,
  output logic                    game_over,
  output logic [1:0]              winner
);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int A_W   = $clog2(CELLS);

  // Heading encoding matches the low two bits of a key code.
  localparam logic [1:0] HD_UP = 2'b00, HD_DN = 2'b01, HD_LF = 2'b10, HD_RT = 2'b11;

  typedef enum logic [3:0] {
    S_CLEAR, S_DRAW0, S_IDLE, S_RUN, S_READ1, S_READ2, S_DECIDE, S_PLOT1, S_PLOT2, S_GAME_OVER
  } state_t;

  typedef struct packed {
    logic           oob;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } mv_t;

  // Off-grid moves leave the coordinate unchanged so the RAM address stays legal;
  // the oob flag alone carries the crash.
  function automatic mv_t next_cell(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                    input logic [1:0] hd);
    mv_t m;
    m.oob = 1'b0;
    m.x   = x;
    m.y   = y;
    case (hd)
      HD_UP:   if (y == '0) m.oob = 1'b1; else m.y = y - Y_W'(1);
      HD_DN:   if (y == Y_W'(GRID_H-1)) m.oob = 1'b1; else m.y = y + Y_W'(1);
      HD_LF:   if (x == '0) m.oob = 1'b1; else m.x = x - X_W'(1);
      default: if (x == X_W'(GRID_W-1)) m.oob = 1'b1; else m.x = x + X_W'(1);
    endcase
    return m;
  endfunction

  // Reversal pairs share bit 1 and differ in bit 0 (up/down, left/right).
  function automatic logic [1:0] steer(input logic [1:0] cur, input logic [1:0] pend,
                                       input logic [2:0] code);
    if (code[2] && !(code[1] == cur[1] && code[0] != cur[0])) return code[1:0];
    return pend;
  endfunction

  function automatic logic [A_W-1:0] addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return A_W'(y) * A_W'(GRID_W) + A_W'(x);
  endfunction

  state_t         state_q, state_d;
  logic           draw_sel_q, draw_sel_d;
  logic [X_W-1:0] x1_q, x1_d, x2_q, x2_d, nx1_q, nx1_d, nx2_q, nx2_d, px_q, px_d;
  logic [Y_W-1:0] y1_q, y1_d, y2_q, y2_d, ny1_q, ny1_d, ny2_q, ny2_d, py_q, py_d;
  logic [1:0]     hd1_q, hd1_d, hd2_q, hd2_d, pd1_q, pd1_d, pd2_q, pd2_d;
  logic           oob1_q, oob1_d, oob2_q, oob2_d, occ1_q, occ1_d;
  logic [2:0]     pc_q, pc_d;
  logic           pv_q, pv_d, go_q, go_d;
  logic [1:0]     win_q, win_d;

  logic           occ_mem [CELLS];
  logic           rdata_q;
  logic [A_W-1:0] ra;
  logic           xfer, same, c1, c2;
  mv_t            m1, m2;

  assign xfer = pv_q & plot.plot_ready;

  // Occupancy is written as each plot transfers: background clears, trails mark.
  // Only RUN..DECIDE read it, by which time every pending plot has landed.
  assign ra = (state_q == S_READ1) ? addr(nx1_q, ny1_q) : addr(nx2_q, ny2_q);

  always_ff @(posedge CLOCK_50) begin
    if (xfer) occ_mem[addr(px_q, py_q)] <= (pc_q != 3'b000);
    rdata_q <= occ_mem[ra];
  end

  always_comb begin
    state_d = state_q; draw_sel_d = draw_sel_q;
    x1_d = x1_q; y1_d = y1_q; x2_d = x2_q; y2_d = y2_q;
    nx1_d = nx1_q; ny1_d = ny1_q; nx2_d = nx2_q; ny2_d = ny2_q;
    oob1_d = oob1_q; oob2_d = oob2_q; occ1_d = occ1_q;
    hd1_d = hd1_q; hd2_d = hd2_q;
    px_d = px_q; py_d = py_q; pc_d = pc_q; pv_d = pv_q;
    go_d = go_q; win_d = win_q;
    pd1_d = steer(hd1_q, pd1_q, KEY_PRESSED[2:0]);
    pd2_d = steer(hd2_q, pd2_q, KEY_PRESSED[5:3]);
    m1 = next_cell(x1_q, y1_q, pd1_q);
    m2 = next_cell(x2_q, y2_q, pd2_q);
    same = (nx1_q == nx2_q) && (ny1_q == ny2_q);
    c1 = oob1_q | occ1_q | same;
    c2 = oob2_q | rdata_q | same;

    case (state_q)
      S_CLEAR: begin
        // px/py double as the raster counter.
        pv_d = 1'b1;
        pc_d = 3'b000;
        if (xfer) begin
          if (px_q == X_W'(GRID_W-1)) begin
            px_d = '0;
            if (py_q == Y_W'(GRID_H-1)) begin
              py_d = '0; pv_d = 1'b0; draw_sel_d = 1'b0; state_d = S_DRAW0;
            end else py_d = py_q + Y_W'(1);
          end else px_d = px_q + X_W'(1);
        end
      end
      S_DRAW0: begin
        if (!pv_q) begin
          pv_d = 1'b1; px_d = x1_q; py_d = y1_q; pc_d = P1_COLOUR;
        end else if (xfer) begin
          if (!draw_sel_q) begin
            draw_sel_d = 1'b1; px_d = x2_q; py_d = y2_q; pc_d = P2_COLOUR;
          end else begin
            pv_d = 1'b0; state_d = S_IDLE;
          end
        end
      end
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: if (clonke) begin
        hd1_d = pd1_q; hd2_d = pd2_q;
        nx1_d = m1.x; ny1_d = m1.y; oob1_d = m1.oob;
        nx2_d = m2.x; ny2_d = m2.y; oob2_d = m2.oob;
        state_d = S_READ1;
      end
      S_READ1: state_d = S_READ2;
      S_READ2: begin
        occ1_d  = rdata_q;
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (c1 | c2) begin
          win_d = {c1, c2}; go_d = 1'b1; state_d = S_GAME_OVER;
        end else begin
          x1_d = nx1_q; y1_d = ny1_q; x2_d = nx2_q; y2_d = ny2_q;
          pv_d = 1'b1; px_d = nx1_q; py_d = ny1_q; pc_d = P1_COLOUR;
          state_d = S_PLOT1;
        end
      end
      S_PLOT1: if (xfer) begin
        px_d = x2_q; py_d = y2_q; pc_d = P2_COLOUR; state_d = S_PLOT2;
      end
      S_PLOT2: if (xfer) begin
        pv_d = 1'b0; state_d = S_RUN;
      end
      S_GAME_OVER: if (start) begin
        go_d = 1'b0; win_d = 2'b00;
        x1_d = X_W'(P1_X0); y1_d = Y_W'(Y0); x2_d = X_W'(P2_X0); y2_d = Y_W'(Y0);
        hd1_d = HD_RT; hd2_d = HD_LF; pd1_d = HD_RT; pd2_d = HD_LF;
        px_d = '0; py_d = '0; pc_d = 3'b000;
        state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_CLEAR; draw_sel_q <= 1'b0;
      x1_q <= X_W'(P1_X0); y1_q <= Y_W'(Y0); x2_q <= X_W'(P2_X0); y2_q <= Y_W'(Y0);
      nx1_q <= '0; ny1_q <= '0; nx2_q <= '0; ny2_q <= '0;
      oob1_q <= 1'b0; oob2_q <= 1'b0; occ1_q <= 1'b0;
      hd1_q <= HD_RT; hd2_q <= HD_LF; pd1_q <= HD_RT; pd2_q <= HD_LF;
      px_q <= '0; py_q <= '0; pc_q <= 3'b000; pv_q <= 1'b0;
      go_q <= 1'b0; win_q <= 2'b00;
    end else begin
      state_q <= state_d; draw_sel_q <= draw_sel_d;
      x1_q <= x1_d; y1_q <= y1_d; x2_q <= x2_d; y2_q <= y2_d;
      nx1_q <= nx1_d; ny1_q <= ny1_d; nx2_q <= nx2_d; ny2_q <= ny2_d;
      oob1_q <= oob1_d; oob2_q <= oob2_d; occ1_q <= occ1_d;
      hd1_q <= hd1_d; hd2_q <= hd2_d; pd1_q <= pd1_d; pd2_q <= pd2_d;
      px_q <= px_d; py_q <= py_d; pc_q <= pc_d; pv_q <= pv_d;
      go_q <= go_d; win_q <= win_d;
    end
  end

  assign plot.plot_x      = px_q;
  assign plot.plot_y      = py_q;
  assign plot.plot_colour = pc_q;
  assign plot.plot_valid  = pv_q;
  assign game_over        = go_q;
  assign winner           = win_q;
endmodule

// File: tb/tb_tron_mechanics.sv
// Directed bench for tron_mechanics: expected plots go into a scoreboard queue
// as stimulus is applied and are matched against transfers seen on the plot stream.
module tb_tron_mechanics;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] key;
  logic       clonke, start;
  logic       game_over;
  logic [1:0] winner;
  int         errors = 0;
  int         checks = 0;

  typedef logic [17:0] plot_t;  // {x[7:0], y[6:0], colour[2:0]}
  plot_t sb[$];

  tron_mechanics_if #(.X_W(8), .Y_W(7)) pif ();

  tron_mechanics dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .KEY_PRESSED(key),
    .clonke     (clonke),
    .start      (start),
    .plot       (pif),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  // Sampled on the falling edge: valid & ready here means a transfer at the next rising edge.
  always @(negedge clk) begin
    if (!rst && pif.plot_valid && pif.plot_ready) begin
      plot_t got, exp;
      int    n;
      got = {pif.plot_x, pif.plot_y, pif.plot_colour};
      n   = sb.size();
      exp = '0;
      if (n > 0) exp = sb.pop_front();
      checks++;
      assert (n > 0 && got === exp) else begin
        errors++;
        $error("FAIL plot: got x=%0d y=%0d c=%b, expected x=%0d y=%0d c=%b (queued=%0d)",
               got[17:10], got[9:3], got[2:0], exp[17:10], exp[9:3], exp[2:0], n);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int x, input int y, input logic [2:0] c);
    logic [7:0] xx;
    logic [6:0] yy;
    xx = 8'(x);
    yy = 7'(y);
    sb.push_back({xx, yy, c});
  endtask

  task automatic push_clear_draw();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) push(x, y, 3'b000);
    push(40, 60, 3'b100);
    push(119, 60, 3'b001);
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin step(); k++; end
    chk(tag, sb.size(), 0);
    step(3);
  endtask

  task automatic tick();
    clonke = 1'b1; step(); clonke = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0; step(2);
  endtask

  initial begin
    rst = 1'b1; key = '0; clonke = 1'b0; start = 1'b0; pif.plot_ready = 1'b1;
    step(2);
    chk("rst_valid",  pif.plot_valid, 0);
    chk("rst_x",      pif.plot_x, 0);
    chk("rst_y",      pif.plot_y, 0);
    chk("rst_colour", pif.plot_colour, 0);
    chk("rst_go",     game_over, 0);
    chk("rst_winner", winner, 0);

    // Full raster clear followed by both start cells.
    push_clear_draw();
    rst = 1'b0;
    drain("clear1", 19300);
    chk("go_after_clear", game_over, 0);
    chk("win_after_clear", winner, 0);

    // A tick outside RUN (in IDLE) is dropped.
    tick(); step(8);
    chk("idle_tick_dropped", sb.size(), 0);

    pulse_start();
    push(41, 60, 3'b100); push(118, 60, 3'b001);
    tick(); drain("move1", 50);

    // Reversal request is ignored.
    key = 6'b000_110; step(); key = '0;
    push(42, 60, 3'b100); push(117, 60, 3'b001);
    tick(); drain("reverse_ignored", 50);

    // P1 turns up; last nonzero code before the tick wins.
    key = 6'b000_101; step(); key = 6'b000_100; step(); key = '0;
    push(42, 59, 3'b100); push(116, 60, 3'b001);
    tick(); drain("turn_up", 50);

    for (int i = 1; i <= 59; i++) begin
      push(42, 59 - i, 3'b100); push(116 - i, 60, 3'b001);
      tick(); drain("climb", 50);
    end

    // P1 runs off the top edge: no plots, P2 wins.
    tick(); step(10);
    chk("edge_no_plot", sb.size(), 0);
    chk("edge_valid", pif.plot_valid, 0);
    chk("edge_go", game_over, 1);
    chk("edge_winner", winner, 2'b10);

    // Restart from GAME_OVER clears and redraws.
    push_clear_draw();
    start = 1'b1; step(); start = 1'b0;
    chk("restart_go", game_over, 0);
    chk("restart_winner", winner, 0);
    drain("clear2", 19300);

    // Stall the display during PLOT1; a tick inside the stall is dropped.
    pulse_start();
    pif.plot_ready = 1'b0;
    push(41, 60, 3'b100); push(118, 60, 3'b001);
    tick();
    begin
      int k = 0;
      while (!pif.plot_valid && k < 10) begin step(); k++; end
    end
    chk("stall_valid_rise", pif.plot_valid, 1);
    for (int i = 0; i < 5; i++) begin
      clonke = (i == 1);
      step();
      chk("stall_valid",  pif.plot_valid, 1);
      chk("stall_x",      pif.plot_x, 41);
      chk("stall_y",      pif.plot_y, 60);
      chk("stall_colour", pif.plot_colour, 3'b100);
    end
    clonke = 1'b0;
    pif.plot_ready = 1'b1;
    drain("stall_release", 50);
    step(10);
    chk("dropped_tick_no_move", sb.size(), 0);

    // Straight run until the heads meet each other's trails on move 40.
    for (int m = 2; m <= 39; m++) begin
      push(40 + m, 60, 3'b100); push(119 - m, 60, 3'b001);
      tick(); drain("straight", 50);
    end
    tick(); step(10);
    chk("draw_no_plot", sb.size(), 0);
    chk("draw_go", game_over, 1);
    chk("draw_winner", winner, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
